// File: rtl/fft_agu_seq_if.sv
// Purpose: sequencer-to-address-calculator bus (start in, read/write butterfly names out).
// Latency: n/a (wires only); write-side copy trails the read side by LAT cycles inside the sequencer.
// Backpressure: none; the consumer must accept one butterfly per cycle while rd_en/wr_en are high.
interface fft_agu_seq_if #(
  parameter int M = 9
);
  logic         start;
  logic [M-1:0] level;
  logic [M-1:0] index;
  logic         rd_en;
  logic         wr_en;
  logic [M-1:0] wr_level;
  logic [M-1:0] wr_index;
  logic         busy;
  logic         done;

  // Sequencer side: takes start, drives the butterfly stream.
  modport master (
    input  start,
    output level,
    output index,
    output rd_en,
    output wr_en,
    output wr_level,
    output wr_index,
    output busy,
    output done
  );

  // Requester / address-calculator side.
  modport slave (
    output start,
    input  level,
    input  index,
    input  rd_en,
    input  wr_en,
    input  wr_level,
    input  wr_index,
    input  busy,
    input  done
  );
endinterface

// File: rtl/fft_agu_seq.sv
// Purpose: radix-2 in-place FFT butterfly sequencer (level/index walk, read strobe, delayed write copy).
// Latency: first read 1 cycle after start; write side trails reads by LAT; done M*(2^(M-1)+LAT)+1 after start.
// Backpressure: none; free-running once started, LAT-cycle drain gap between levels, start ignored while active.
module fft_agu_seq #(
  parameter int M   = 9,
  parameter int LAT = 3
) (
  input  logic          clk,
  input  logic          reset,
  fft_agu_seq_if.master bus
);

  // Drain counter is 5 bits so the full LAT range 1..16 fits.
  localparam int           CNT_W      = 5;
  localparam logic [M-1:0] IDX_LAST   = {1'b0, {(M-1){1'b1}}};
  localparam logic [M-1:0] LEVEL_LAST = M'(M - 1);
  localparam logic [M-1:0] ONE        = M'(1);
  localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(LAT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [M-1:0]     level_q, level_d;
  logic [M-1:0]     index_q, index_d;
  logic             rd_en_q, rd_en_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [CNT_W-1:0] drain_cnt_q, drain_cnt_d;

  // Write-side delay line: stage 0 holds last cycle's read, stage LAT-1 is the write-back.
  logic [LAT-1:0]   sh_en_q, sh_en_d;
  logic [M-1:0]     sh_level_q [LAT];
  logic [M-1:0]     sh_level_d [LAT];
  logic [M-1:0]     sh_index_q [LAT];
  logic [M-1:0]     sh_index_d [LAT];

  // Next-state and next-output computation; all outputs are registered so they change only on the edge.
  always_comb begin
    state_d     = state_q;
    level_d     = level_q;
    index_d     = index_q;
    rd_en_d     = rd_en_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    drain_cnt_d = drain_cnt_q;

    unique case (state_q)
      S_IDLE: begin
        level_d = '0;
        index_d = '0;
        rd_en_d = 1'b0;
        busy_d  = 1'b0;
        if (bus.start) begin
          state_d = S_RUN;
          rd_en_d = 1'b1;
          busy_d  = 1'b1;
        end
      end

      S_RUN: begin
        // Last butterfly of the level: stop reading and hold the name while writes drain.
        if (index_q == IDX_LAST) begin
          state_d     = S_DRAIN;
          rd_en_d     = 1'b0;
          drain_cnt_d = '0;
        end else begin
          index_d = index_q + ONE;
        end
      end

      S_DRAIN: begin
        // The last write of this level issues in the final drain cycle, so the next
        // level's first read lands one cycle after it is committed.
        if (drain_cnt_q == DRAIN_LAST) begin
          if (level_q != LEVEL_LAST) begin
            state_d = S_RUN;
            level_d = level_q + ONE;
            index_d = '0;
            rd_en_d = 1'b1;
          end else begin
            state_d = S_DONE;
            done_d  = 1'b1;
            busy_d  = 1'b0;
            level_d = '0;
            index_d = '0;
          end
        end else begin
          drain_cnt_d = drain_cnt_q + CNT_W'(1);
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Delay line shifts every cycle regardless of state; it never stalls.
  always_comb begin
    sh_en_d[0]    = rd_en_q;
    sh_level_d[0] = level_q;
    sh_index_d[0] = index_q;
    for (int i = 1; i < LAT; i++) begin
      sh_en_d[i]    = sh_en_q[i-1];
      sh_level_d[i] = sh_level_q[i-1];
      sh_index_d[i] = sh_index_q[i-1];
    end
  end

  // Sequencer state and registered outputs; reset aborts a transform without a done pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      level_q     <= '0;
      index_q     <= '0;
      rd_en_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      drain_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      level_q     <= level_d;
      index_q     <= index_d;
      rd_en_q     <= rd_en_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      drain_cnt_q <= drain_cnt_d;
    end
  end

  // Write-side delay line registers, fully cleared on reset so no stale write escapes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sh_en_q <= '0;
      for (int i = 0; i < LAT; i++) begin
        sh_level_q[i] <= '0;
        sh_index_q[i] <= '0;
      end
    end else begin
      sh_en_q <= sh_en_d;
      for (int i = 0; i < LAT; i++) begin
        sh_level_q[i] <= sh_level_d[i];
        sh_index_q[i] <= sh_index_d[i];
      end
    end
  end

  assign bus.level    = level_q;
  assign bus.index    = index_q;
  assign bus.rd_en    = rd_en_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.wr_en    = sh_en_q[LAT-1];
  assign bus.wr_level = sh_level_q[LAT-1];
  assign bus.wr_index = sh_index_q[LAT-1];

endmodule

// File: tb/tb_fft_agu_seq.sv
// Purpose: scoreboard bench for fft_agu_seq (M=9/LAT=3 main instance, M=4/LAT=1 side instance).
// Latency: expected reads/writes/done are timestamped by cycle from the start acceptance cycle.
// Backpressure: none in the design; stimulus is random start pulses, held start and a mid-cycle reset.
module tb_fft_agu_seq;

  localparam int M   = 9;
  localparam int LAT = 3;
  localparam int H   = 1 << (M - 1);
  localparam int T   = M * (H + LAT);

  typedef struct {
    int c;
    int l;
    int i;
  } ev_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_err = 0;

  ev_t  rdq [$];
  ev_t  wrq [$];
  int   dq  [$];
  int   busy_lo = 0;
  int   busy_hi = -1;
  int   next_idle = 0;

  fft_agu_seq_if #(.M(M)) bus ();
  fft_agu_seq_if #(.M(4)) bus2 ();

  fft_agu_seq #(.M(M), .LAT(LAT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  fft_agu_seq #(.M(4), .LAT(1)) dut2 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus2)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
    end
  endtask

  // Reference model: a transform accepted in cycle c reads butterfly (L,I) in
  // cycle c+1+L*(H+LAT)+I, writes it LAT cycles later, is busy c+1..c+T,
  // pulses done at c+T+1 and is idle again from c+T+2.
  task automatic accept(input int c);
    for (int l = 0; l < M; l++) begin
      for (int i = 0; i < H; i++) begin
        rdq.push_back('{c + 1 + l * (H + LAT) + i, l, i});
        wrq.push_back('{c + 1 + l * (H + LAT) + i + LAT, l, i});
      end
    end
    dq.push_back(c + T + 1);
    busy_lo   = c + 1;
    busy_hi   = c + T;
    next_idle = c + T + 2;
  endtask

  task automatic drive(input bit s);
    @(negedge clk);
    #1;
    bus.start = s;
    if (s && cyc >= next_idle) accept(cyc);
  endtask

  task automatic chk_all_zero(input string name);
    chk(name, int'({bus.rd_en, bus.wr_en, bus.busy, bus.done,
                    |bus.level, |bus.index, |bus.wr_level, |bus.wr_index}), 0);
  endtask

  // Monitor: every cycle compare the DUT's outputs with whatever the scoreboard expects now.
  always @(negedge clk) begin : monitor
    ev_t e;
    bit  er, ew, ed, eb;
    er = (rdq.size() > 0) && (rdq[0].c == cyc);
    ew = (wrq.size() > 0) && (wrq[0].c == cyc);
    ed = (dq.size() > 0) && (dq[0] == cyc);
    eb = (cyc >= busy_lo) && (cyc <= busy_hi);
    chk("rd_en", int'(bus.rd_en), int'(er));
    if (er) begin
      e = rdq.pop_front();
      if (bus.rd_en) begin
        chk("level", int'(bus.level), e.l);
        chk("index", int'(bus.index), e.i);
      end
    end
    chk("wr_en", int'(bus.wr_en), int'(ew));
    if (ew) begin
      e = wrq.pop_front();
      if (bus.wr_en) begin
        chk("wr_level", int'(bus.wr_level), e.l);
        chk("wr_index", int'(bus.wr_index), e.i);
      end
    end
    chk("done", int'(bus.done), int'(ed));
    if (ed) void'(dq.pop_front());
    chk("busy", int'(bus.busy), int'(eb));
  end

  // Small configuration: M=4, LAT=1 gives 8 reads per level, 1 drain cycle, done at +37.
  initial begin : small_cfg
    int c0, reads, writes, dcyc, last_l, last_i;
    bus2.start = 1'b0;
    reads = 0; writes = 0; dcyc = -1; last_l = -1; last_i = -1;
    repeat (10) @(negedge clk);
    #1;
    bus2.start = 1'b1;
    c0 = cyc;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (k == 0) bus2.start = 1'b0;
      if (bus2.rd_en) begin
        reads++;
        if (reads == 1) begin
          chk("m4_first_read_cycle", cyc, c0 + 1);
          chk("m4_first_read_name", int'({bus2.level, bus2.index}), 0);
        end
        last_l = int'(bus2.level);
        last_i = int'(bus2.index);
      end
      if (bus2.wr_en) writes++;
      if (bus2.done) dcyc = cyc;
    end
    chk("m4_done_cycle", dcyc, c0 + 37);
    chk("m4_reads", reads, 32);
    chk("m4_writes", writes, 32);
    chk("m4_last_level", last_l, 3);
    chk("m4_last_index", last_i, 7);
  end

  initial begin : stimulus
    bus.start = 1'b0;
    #2 reset = 1'b1;
    #1 chk_all_zero("reset_state");
    repeat (3) @(negedge clk);
    #1 reset = 1'b0;
    next_idle = cyc;

    // Single transform with ignored start pulses at +100, at the DONE cycle, and random ones in between.
    repeat ($urandom_range(2, 10)) drive(1'b0);
    drive(1'b1);
    for (int k = 1; k <= T + 1; k++)
      drive((k == 100) || (k == T + 1) || ($urandom_range(0, 63) == 0));
    repeat (5) drive(1'b0);

    // Start held high: two back-to-back transforms, second one reads 2 cycles after done.
    for (int k = 0; k < 2 * (T + 2); k++) drive(1'b1);
    repeat (T + 10) drive(1'b0);

    // Reset asserted mid-cycle part way through a transform.
    drive(1'b1);
    repeat ($urandom_range(900, 1100)) drive(1'b0);
    #2 reset = 1'b1;
    #1 chk_all_zero("async_reset_clears");
    rdq.delete();
    wrq.delete();
    dq.delete();
    busy_hi = -1;
    repeat (4) @(negedge clk);
    #1 reset = 1'b0;
    next_idle = cyc;
    repeat ($urandom_range(1, 5)) drive(1'b0);
    drive(1'b1);
    repeat (T + 5) drive(1'b0);

    chk("reads_outstanding", rdq.size(), 0);
    chk("writes_outstanding", wrq.size(), 0);
    chk("done_outstanding", dq.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/fft_agu_seq.md
# fft_agu_seq

Butterfly sequencer for the in-place radix-2 FFT address generation unit. It sits directly upstream of the AGU address calculator and drives its `level`/`index` inputs. It steps through all M levels × 2^(M-1) butterflies per transform. It also emits a read strobe and a delayed write-side copy (`wr_en`/`wr_level`/`wr_index`) that feeds a second address-calculator instance for write-back. It inserts drain gaps between levels so that no butterfly reads a location still in flight from the previous level.

## Interface
- `M`, 9, log2 of FFT size N; N/2 = 2^(M-1) butterflies per level.
- `LAT`, 3, cycles from butterfly read issue to its write-back issue; legal range 1..16.

- `clk`  in  1  system clock; all state changes on rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state and outputs immediately.
- `start`  in  1  begin one transform; sampled only in IDLE.
- `level`  out  M  current read level, 0..M-1.
- `index`  out  M  current read butterfly index, 0..2^(M-1)-1; MSB always 0.
- `rd_en`  out  1  high when `level`/`index` name a valid butterfly read this cycle.
- `wr_en`  out  1  `rd_en` delayed exactly LAT cycles.
- `wr_level`  out  M  `level` delayed exactly LAT cycles.
- `wr_index`  out  M  `index` delayed exactly LAT cycles.
- `busy`  out  1  high in RUN and DRAIN.
- `done`  out  1  single-cycle pulse after the final write-back has issued.

## Operation
- States: IDLE, RUN, DRAIN, DONE.
- IDLE: `level`=0, `index`=0, `rd_en`=0. `start`=1 → RUN with `level`=0, `index`=0.
- RUN: `rd_en`=1 every cycle and `index` increments by 1 each cycle.
  - When `index` = 2^(M-1)-1, the next state is DRAIN. `level` and `index` hold their last values.
- DRAIN: `rd_en`=0 for exactly LAT cycles, counted by a drain counter of width ≥ 5. `level` and `index` hold.
  - On the final drain cycle, if `level` < M-1: next state is RUN with `level`+1 and `index`=0.
  - Otherwise the next state is DONE.
- DONE: `done`=1 for one cycle, `level`/`index` return to 0, next state is IDLE.
- Write side: a LAT-deep shift register carries {`rd_en`, `level`, `index`}. It shifts every cycle in all states, with no stall.
- No wrap within a level: `index` never exceeds 2^(M-1)-1 and `level` never exceeds M-1.
- `start` is ignored in RUN, DRAIN and DONE; it is not queued. If `start` is held high, a new transform begins on the cycle after DONE, because IDLE samples it.
- Reset mid-operation clears the state to IDLE, zeroes the counters and the whole shift register, and deasserts `busy`/`done`/`rd_en`/`wr_en` at once. No `done` is produced for the aborted transform.

## Timing
- Reset values: all outputs 0; state IDLE.
- Let cycle 0 be the cycle in which `start`=1 is sampled in IDLE. The first read (`rd_en`=1, level 0, index 0) occurs in cycle 1.
- Level L reads occupy cycles 1+L·(2^(M-1)+LAT) through 2^(M-1)+L·(2^(M-1)+LAT).
- The last write-back of level L is issued in the final DRAIN cycle. The first read of level L+1 follows one cycle later, so a synchronous-write RAM sees the committed data.
- `done` is asserted in cycle M·(2^(M-1)+LAT)+1. `busy` is high in cycles 1 through M·(2^(M-1)+LAT).
- Per transform: exactly M·2^(M-1) `rd_en` cycles and the same number of `wr_en` cycles.

## Test plan
- Full run, M=9, LAT=3, `start` pulse at cycle 0:
  - `rd_en` first high at cycle 1 (L0, I0); last L0 read at cycle 256 (I255).
  - DRAIN in cycles 257–259; L1 I0 read at cycle 260.
  - Last read L8 I255 at cycle 2328; `done` only at cycle 2332.
  - 2304 reads and 2304 writes in total.
- Write alignment: in every cycle, {`wr_en`, `wr_level`, `wr_index`} equals {`rd_en`, `level`, `index`} from 3 cycles earlier. `wr_en`=1 during DRAIN cycles 257–259 (L0 I253..I255).
- `start` pulsed at cycles 100 and 2332 (the DONE cycle) → both ignored. The timeline is identical to the full-run scenario, and the system returns to IDLE at cycle 2333.
- `reset` asserted asynchronously at cycle 1000 (mid-clock) → all outputs 0 before the next edge. `wr_en` stays 0 for the following 3 cycles and no `done` is produced. A new `start` then yields a first read 1 cycle later.
- M=4, LAT=1: 8 reads per level with 1 DRAIN cycle. `done` at cycle 4·9+1 = 37; 32 reads.
- `start` held high continuously → back-to-back transforms. The second transform's first read occurs 2 cycles after the first transform's `done`.
